// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
// Includes the fetch FSM states, the queue-entry payload and the B/J immediate decoders.
package fetch_pkg;

    localparam int unsigned PC_W   = 64;
    localparam int unsigned INSN_W = 32;

    localparam logic [INSN_W-1:0] NOP_INSN   = 32'h00000013;
    localparam logic [INSN_W-1:0] HALT_INSN  = 32'h00000063;
    localparam logic [6:0]        OPC_BRANCH = 7'b1100011;
    localparam logic [6:0]        OPC_JAL    = 7'b1101111;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HALT  = 2'd1,
        FAULT = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic [INSN_W-1:0] instr;
        logic              pred;
    } fetch_entry_t;

    // Sign-extended branch offset
    function automatic logic [PC_W-1:0] imm_b(input logic [INSN_W-1:0] insn);
        return {{51{insn[31]}}, insn[31], insn[7], insn[30:25], insn[11:8], 1'b0};
    endfunction

    // Sign-extended jump offset
    function automatic logic [PC_W-1:0] imm_j(input logic [INSN_W-1:0] insn);
        return {{43{insn[31]}}, insn[31], insn[19:12], insn[20], insn[30:21], 1'b0};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small fetch queue: flush wins over push/pop, and a push into a full queue
// is accepted when a pop happens in the same cycle.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_flush,
    input  logic                     i_push,
    input  fetch_entry_t             i_data,
    input  logic                     i_pop,
    output fetch_entry_t             o_head,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    fetch_entry_t     r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign w_do_pop  = i_pop && !i_flush && (r_count != '0);
    assign w_do_push = i_push && !i_flush && ((r_count != CNT_W'(DEPTH)) || w_do_pop);

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (!w_do_push && w_do_pop) begin
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: owns the PC, queues fetched words for decode, handles
// redirects, halt and fetch faults. Define FETCH_STATIC_BTFN_EN for static BTFN/JAL prediction.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter logic [63:0] RESET_PC   = 64'h0,
    parameter int unsigned IMEM_BYTES = 208,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic [63:0] imem_addr,
    input  logic [31:0] imem_instr,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [63:0] if_pc,
    output logic [31:0] if_instr,
    output logic        if_pred_taken,
    output logic        halted,
    output logic        fault
);

    localparam int unsigned CNT_W   = $clog2(FIFO_DEPTH) + 1;
    localparam logic [63:0] LAST_PC = 64'(IMEM_BYTES - 4);

    fetch_state_e     r_state;
    fetch_state_e     w_state_nxt;
    logic [63:0]      r_pc;
    logic [63:0]      w_pc_nxt;
    logic [63:0]      w_tgt;
    logic             w_pred;
    logic             w_push;
    logic             w_pop;
    logic [CNT_W-1:0] w_count;
    fetch_entry_t     w_push_data;
    fetch_entry_t     w_head;

    assign w_pop = if_valid && if_ready;

`ifdef FETCH_STATIC_BTFN_EN
    // Backward conditional branches and all JALs are predicted taken
    always_comb begin
        w_pred = 1'b0;
        w_tgt  = r_pc + 64'd4;
        if ((imem_instr[6:0] == OPC_BRANCH) && imem_instr[31]) begin
            w_pred = 1'b1;
            w_tgt  = r_pc + imm_b(imem_instr);
        end else if (imem_instr[6:0] == OPC_JAL) begin
            w_pred = 1'b1;
            w_tgt  = r_pc + imm_j(imem_instr);
        end
    end
`else
    assign w_pred = 1'b0;
    assign w_tgt  = r_pc + 64'd4;
`endif

    assign w_push_data = '{pc: r_pc, instr: imem_instr, pred: w_pred};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= FETCH;
            r_pc    <= RESET_PC;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
        end
    end

    // Redirect overrides everything; the address check precedes any push
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_push      = 1'b0;
        if (redirect_valid) begin
            w_state_nxt = FETCH;
            w_pc_nxt    = redirect_pc;
        end else if (r_state == FETCH) begin
            if ((r_pc > LAST_PC) || (r_pc[1:0] != 2'b00)) begin
                w_state_nxt = FAULT;
            end else if ((w_count < CNT_W'(FIFO_DEPTH)) || w_pop) begin
                w_push = 1'b1;
                if (imem_instr == HALT_INSN) begin
                    w_state_nxt = HALT;
                end else begin
                    w_pc_nxt = w_tgt;
                end
            end
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (reset),
        .i_flush (redirect_valid),
        .i_push  (w_push),
        .i_data  (w_push_data),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_count (w_count)
    );

    assign imem_addr     = r_pc;
    assign if_valid      = (w_count != '0);
    assign if_pc         = if_valid ? w_head.pc : 64'h0;
    assign if_instr      = if_valid ? w_head.instr : NOP_INSN;
    assign if_pred_taken = if_valid && w_head.pred;
    assign halted        = (r_state == HALT);
    assign fault         = (r_state == FAULT);

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized redirects and backpressure.
`timescale 1ns/1ps
module tb_fetch_sequencer;

    localparam int unsigned IMEM_BYTES = 208;
    localparam int unsigned NWORDS     = IMEM_BYTES / 4;
    localparam int          DEPTH      = 2;
    localparam logic [31:0] NOP        = 32'h00000013;
    localparam int          RUN        = 0;
    localparam int          HLT        = 1;
    localparam int          FLT        = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic [63:0] imem_addr;
    logic [31:0] imem_instr;
    logic        if_valid;
    logic        if_ready;
    logic [63:0] if_pc;
    logic [31:0] if_instr;
    logic        if_pred_taken;
    logic        halted;
    logic        fault;

    fetch_sequencer dut (
        .clk            (clk),
        .reset          (reset),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_addr      (imem_addr),
        .imem_instr     (imem_instr),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_pc          (if_pc),
        .if_instr       (if_instr),
        .if_pred_taken  (if_pred_taken),
        .halted         (halted),
        .fault          (fault)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [NWORDS];

    function automatic logic [31:0] read_word(input logic [63:0] a);
        if (a < 64'(IMEM_BYTES)) return mem[a[7:2]];
        return 32'h0;
    endfunction

    assign imem_instr = read_word(imem_addr);

    typedef struct {
        logic [63:0] pc;
        logic [31:0] instr;
        logic        pred;
    } ent_t;

    ent_t        q[$];
    logic [63:0] m_pc   = 64'h0;
    int          m_mode = RUN;
    bit          chk_en = 1'b0;
    int          n_total = 0;
    int          n_bad   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Next fetch address and prediction bit from ISA immediate arithmetic
    function automatic void predict(input logic [63:0] pc, input logic [31:0] w,
                                    output logic [63:0] nxt, output logic pred);
`ifdef FETCH_STATIC_BTFN_EN
        longint off;
`endif
        nxt  = pc + 64'd4;
        pred = 1'b0;
`ifdef FETCH_STATIC_BTFN_EN
        if (w[6:0] == 7'h63 && w[31]) begin
            off  = -4096 + longint'(w[7]) * 2048 + longint'(w[30:25]) * 32 + longint'(w[11:8]) * 2;
            nxt  = pc + 64'(off);
            pred = 1'b1;
        end else if (w[6:0] == 7'h6F) begin
            off  = (w[31] ? -1048576 : 0) + longint'(w[19:12]) * 4096 + longint'(w[20]) * 2048
                 + longint'(w[30:21]) * 2;
            nxt  = pc + 64'(off);
            pred = 1'b1;
        end
`endif
    endfunction

    task automatic model_reset();
        q.delete();
        m_pc   = 64'h0;
        m_mode = RUN;
    endtask

    task automatic model_step(input logic rv, input logic [63:0] rpc, input logic rdy);
        int          sz;
        bit          pop;
        logic [31:0] w;
        logic [63:0] nxt;
        logic        pr;
        sz  = q.size();
        pop = (sz > 0) && rdy;
        if (rv) begin
            q.delete();
            m_pc   = rpc;
            m_mode = RUN;
            return;
        end
        if (pop) void'(q.pop_front());
        if (m_mode == RUN) begin
            if (m_pc > 64'(IMEM_BYTES - 4) || m_pc % 4 != 0) begin
                m_mode = FLT;
            end else if (sz < DEPTH || pop) begin
                w = read_word(m_pc);
                predict(m_pc, w, nxt, pr);
                q.push_back('{pc: m_pc, instr: w, pred: pr});
                if (w == 32'h00000063) m_mode = HLT;
                else m_pc = nxt;
            end
        end
    endtask

    // Compare DUT against the model shortly after every active edge
    always @(posedge clk) begin
        logic        ev;
        logic [63:0] epc;
        logic [31:0] ei;
        logic        ep;
        #2;
        if (chk_en) begin
            if (q.size() != 0) begin
                ev = 1'b1; epc = q[0].pc; ei = q[0].instr; ep = q[0].pred;
            end else begin
                ev = 1'b0; epc = 64'h0; ei = NOP; ep = 1'b0;
            end
            chk("m_valid", 64'(if_valid), 64'(ev));
            chk("m_pc", if_pc, epc);
            chk("m_instr", 64'(if_instr), 64'(ei));
            chk("m_pred", 64'(if_pred_taken), 64'(ep));
            chk("m_halted", 64'(halted), 64'(m_mode == HLT));
            chk("m_fault", 64'(fault), 64'(m_mode == FLT));
            chk("m_addr", imem_addr, m_pc);
        end
    end

    // Called at a falling edge; returns at the next falling edge
    task automatic cycle(input logic rv, input logic [63:0] rpc, input logic rdy);
        redirect_valid = rv;
        redirect_pc    = rpc;
        if_ready       = rdy;
        model_step(rv, rpc, rdy);
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 64'h0;
        if_ready       = 1'b0;
        #1;
        chk("rst_valid", 64'(if_valid), 64'h0);
        chk("rst_pc", if_pc, 64'h0);
        chk("rst_instr", 64'(if_instr), 64'(NOP));
        chk("rst_pred", 64'(if_pred_taken), 64'h0);
        chk("rst_halted", 64'(halted), 64'h0);
        chk("rst_fault", 64'(fault), 64'h0);
        chk("rst_addr", imem_addr, 64'h0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic init_mem();
        logic [31:0] r;
        for (int i = 0; i < int'(NWORDS); i++) begin
            r      = $urandom();
            mem[i] = {r[31:7], (r[0] ? 7'h13 : 7'h33)};
        end
        mem[0]  = 32'h00000513;
        mem[1]  = 32'h00100293;
        mem[2]  = 32'h00A2B023;
        mem[4]  = 32'h00000463;
        mem[12] = 32'h0200006F;
        mem[22] = 32'h00000293;
        mem[40] = 32'hFC000CE3;
        mem[51] = 32'h00000063;
    endtask

    initial begin
        logic        rv;
        logic [63:0] rpc;
        logic        rdy;
        reset          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 64'h0;
        if_ready       = 1'b0;
        init_mem();
        @(negedge clk);
        do_reset();
        chk_en = 1'b1;

        // Streaming from reset with decode always ready
        cycle(1'b0, 64'h0, 1'b1);
        chk("t1_pc0", if_pc, 64'h0);
        chk("t1_in0", 64'(if_instr), 64'h00000513);
        cycle(1'b0, 64'h0, 1'b1);
        chk("t1_pc1", if_pc, 64'h4);
        chk("t1_in1", 64'(if_instr), 64'h00100293);
        cycle(1'b0, 64'h0, 1'b1);
        chk("t1_pc2", if_pc, 64'h8);
        chk("t1_in2", 64'(if_instr), 64'h00A2B023);

        // Backpressure: queue fills, head and fetch address freeze
        do_reset();
        repeat (5) cycle(1'b0, 64'h0, 1'b0);
        chk("t2_valid", 64'(if_valid), 64'h1);
        chk("t2_head", if_pc, 64'h0);
        chk("t2_addr", imem_addr, 64'h8);
        cycle(1'b0, 64'h0, 1'b1);
        chk("t2_pc1", if_pc, 64'h4);
        cycle(1'b0, 64'h0, 1'b1);
        chk("t2_pc2", if_pc, 64'h8);

        // Redirect while full flushes everything
        cycle(1'b1, 64'h58, 1'b1);
        chk("t3_flush", 64'(if_valid), 64'h0);
        chk("t3_addr", imem_addr, 64'h58);
        cycle(1'b0, 64'h0, 1'b1);
        chk("t3_pc", if_pc, 64'h58);
        chk("t3_in", 64'(if_instr), 64'h00000293);
        cycle(1'b0, 64'h0, 1'b1);
        chk("t3_next", if_pc, 64'h5C);

        // Misaligned and out-of-range redirects fault one cycle later
        cycle(1'b1, 64'h5A, 1'b1);
        chk("t4_nofault", 64'(fault), 64'h0);
        cycle(1'b0, 64'h0, 1'b1);
        chk("t4_fault", 64'(fault), 64'h1);
        chk("t4_valid", 64'(if_valid), 64'h0);
        chk("t4_addr", imem_addr, 64'h5A);
        cycle(1'b1, 64'h0, 1'b1);
        chk("t4_clear", 64'(fault), 64'h0);
        cycle(1'b1, 64'hD0, 1'b1);
        cycle(1'b0, 64'h0, 1'b1);
        chk("t4_oor", 64'(fault), 64'h1);
        cycle(1'b1, 64'hCC, 1'b1);
        cycle(1'b0, 64'h0, 1'b1);
        chk("t4_last", 64'(if_pc), 64'hCC);

        // Halt word stops fetching; reset mid-halt
        cycle(1'b1, 64'hC8, 1'b1);
        cycle(1'b0, 64'h0, 1'b1);
        cycle(1'b0, 64'h0, 1'b1);
        chk("t5_halted", 64'(halted), 64'h1);
        chk("t5_in", 64'(if_instr), 64'h00000063);
        chk("t5_addr", imem_addr, 64'hCC);
        cycle(1'b0, 64'h0, 1'b0);
        cycle(1'b0, 64'h0, 1'b0);
        chk("t5_hold", imem_addr, 64'hCC);
        do_reset();

        // Backward branch at 0xA0
        cycle(1'b1, 64'hA0, 1'b1);
        cycle(1'b0, 64'h0, 1'b1);
        chk("t6_pc", if_pc, 64'hA0);
`ifdef FETCH_STATIC_BTFN_EN
        chk("t6_pred", 64'(if_pred_taken), 64'h1);
        cycle(1'b0, 64'h0, 1'b1);
        chk("t6_next", if_pc, 64'h78);
`else
        chk("t6_pred", 64'(if_pred_taken), 64'h0);
        cycle(1'b0, 64'h0, 1'b1);
        chk("t6_next", if_pc, 64'hA4);
`endif

        // Randomized redirects and decode backpressure
        for (int i = 0; i < 3000; i++) begin
            rv = ($urandom_range(0, 11) == 0);
            case ($urandom_range(0, 9))
                0:       rpc = {$urandom(), $urandom()};
                1:       rpc = 64'($urandom_range(0, 51)) * 64'd4 + 64'($urandom_range(1, 3));
                2:       rpc = 64'(IMEM_BYTES) + 64'($urandom_range(0, 3)) * 64'd4;
                default: rpc = 64'($urandom_range(0, 51)) * 64'd4;
            endcase
            rdy = ($urandom_range(0, 9) < 7);
            cycle(rv, rpc, rdy);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
